// File: rtl/uart_tx_frame_serializer.sv
// UART transmit serializer: start bit, DATA_W data bits LSB-first, optional parity,
// one or two stop bits; back-to-back frames when send stays high.
module uart_tx_frame_serializer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              baud_clk,
   input  logic              reset_n,
   input  logic              send,
   input  logic [DATA_W-1:0] reg_data,
   input  logic [1:0]        parity_type,
   input  logic              stop_bits,
   output logic              data_tx,
   output logic              active_flag,
   output logic              done_flag
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state,   w_state_nxt;
   logic [DATA_W-1:0] r_shift,   w_shift_nxt;
   logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
   logic              r_par_en,  w_par_en_nxt;
   logic              r_par_bit, w_par_bit_nxt;
   logic              r_stop2,   w_stop2_nxt;
   logic              r_data_tx, w_tx_nxt;
   logic              r_active,  w_active_nxt;
   logic              r_done,    w_done_nxt;
   logic              w_accept;
   logic              w_par_en;
   logic              w_par_bit;

   // Parity enable/value for the word presented on the input; 11 acts as none
   assign w_par_en  = (parity_type == 2'b01) || (parity_type == 2'b10);
   assign w_par_bit = (parity_type == 2'b10) ? (^reg_data) : (~^reg_data);

   // Next-state and next-output logic; outputs are registered from these values
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_cnt_nxt     = r_cnt;
      w_par_en_nxt  = r_par_en;
      w_par_bit_nxt = r_par_bit;
      w_stop2_nxt   = r_stop2;
      w_tx_nxt      = 1'b1;
      w_done_nxt    = 1'b0;
      w_accept      = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_accept = send;
         end
         S_START: begin
            w_state_nxt = S_DATA;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = r_shift >> 1;
            w_cnt_nxt   = '0;
         end
         S_DATA: begin
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
               w_cnt_nxt = '0;
               if (r_par_en) begin
                  w_state_nxt = S_PARITY;
                  w_tx_nxt    = r_par_bit;
               end else begin
                  w_state_nxt = S_STOP;
               end
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
            end
         end
         S_PARITY: begin
            w_state_nxt = S_STOP;
            w_cnt_nxt   = '0;
         end
         S_STOP: begin
            if (r_stop2 && (r_cnt == '0)) begin
               w_cnt_nxt = CNT_W'(1);
            end else begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
               w_accept    = send;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Accepting from IDLE or on the last stop edge both launch a start bit
      if (w_accept) begin
         w_state_nxt   = S_START;
         w_shift_nxt   = reg_data;
         w_cnt_nxt     = '0;
         w_par_en_nxt  = w_par_en;
         w_par_bit_nxt = w_par_bit;
         w_stop2_nxt   = stop_bits;
         w_tx_nxt      = 1'b0;
      end

      w_active_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_stop2   <= 1'b0;
         r_data_tx <= 1'b1;
         r_active  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_cnt     <= w_cnt_nxt;
         r_par_en  <= w_par_en_nxt;
         r_par_bit <= w_par_bit_nxt;
         r_stop2   <= w_stop2_nxt;
         r_data_tx <= w_tx_nxt;
         r_active  <= w_active_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign data_tx     = r_data_tx;
   assign active_flag = r_active;
   assign done_flag   = r_done;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer (DATA_W=8) with hand-computed frame bit patterns.
module tb_uart_tx_frame_serializer;

   logic       clk;
   logic       reset_n;
   logic       send;
   logic [7:0] reg_data;
   logic [1:0] parity_type;
   logic       stop_bits;
   logic       data_tx;
   logic       active_flag;
   logic       done_flag;

   int vectors;
   int miscompares;

   uart_tx_frame_serializer #(.DATA_W(8)) dut (
      .baud_clk    (clk),
      .reset_n     (reset_n),
      .send        (send),
      .reg_data    (reg_data),
      .parity_type (parity_type),
      .stop_bits   (stop_bits),
      .data_tx     (data_tx),
      .active_flag (active_flag),
      .done_flag   (done_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Walks one frame bit per negedge; bit i of 'bits' is the i-th line bit
   task automatic run_frame(input string name, input logic [11:0] bits, input int len,
                            input logic first_done, input logic hold, input logic mutate);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         chk($sformatf("%s tx[%0d]", name, i), data_tx, bits[i]);
         chk($sformatf("%s active[%0d]", name, i), active_flag, 1'b1);
         chk($sformatf("%s done[%0d]", name, i), done_flag, (i == 0) ? first_done : 1'b0);
         if (i == 0 && !hold) send = 1'b0;
         if (i == 3 && mutate) begin
            reg_data    = 8'hB5;
            parity_type = 2'b10;
         end
      end
   endtask

   task automatic frame_end(input string name);
      @(negedge clk);
      chk({name, " end done"},   done_flag,   1'b1);
      chk({name, " end active"}, active_flag, 1'b0);
      chk({name, " end tx"},     data_tx,     1'b1);
      @(negedge clk);
      chk({name, " idle done"},  done_flag,   1'b0);
      chk({name, " idle tx"},    data_tx,     1'b1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      send        = 1'b0;
      reg_data    = 8'h4A;
      parity_type = 2'b00;
      stop_bits   = 1'b0;

      // Reset state
      #100;
      chk("rst tx",     data_tx,     1'b1);
      chk("rst active", active_flag, 1'b0);
      chk("rst done",   done_flag,   1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle tx",     data_tx,     1'b1);
      chk("idle active", active_flag, 1'b0);

      // No parity, one stop: 0,0,1,0,1,0,0,1,0,1
      send = 1'b1;
      run_frame("none", 12'h294, 10, 1'b0, 1'b0, 1'b0);
      frame_end("none");

      // Odd parity: parity bit 0
      parity_type = 2'b01;
      send = 1'b1;
      run_frame("odd", 12'h494, 11, 1'b0, 1'b0, 1'b0);
      frame_end("odd");

      // Even parity: parity bit 1
      parity_type = 2'b10;
      send = 1'b1;
      run_frame("even", 12'h694, 11, 1'b0, 1'b0, 1'b0);
      frame_end("even");

      // Even parity, two stop bits
      stop_bits = 1'b1;
      send = 1'b1;
      run_frame("stop2", 12'hE94, 12, 1'b0, 1'b0, 1'b0);
      frame_end("stop2");

      // Parity encoding 11 behaves as none
      stop_bits   = 1'b0;
      parity_type = 2'b11;
      send = 1'b1;
      run_frame("p11", 12'h294, 10, 1'b0, 1'b0, 1'b0);
      frame_end("p11");

      // Three back-to-back frames with send held
      parity_type = 2'b00;
      send = 1'b1;
      run_frame("b2b0", 12'h294, 10, 1'b0, 1'b1, 1'b0);
      run_frame("b2b1", 12'h294, 10, 1'b1, 1'b1, 1'b0);
      run_frame("b2b2", 12'h294, 10, 1'b1, 1'b0, 1'b0);
      frame_end("b2b");

      // Reset during data bit 4 (line index 5, value 0)
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      chk("abort start", data_tx, 1'b0);
      repeat (5) @(negedge clk);
      chk("abort bit4",   data_tx,     1'b0);
      chk("abort active", active_flag, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("abort tx",     data_tx,     1'b1);
      chk("abort act0",   active_flag, 1'b0);
      chk("abort done",   done_flag,   1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post-abort done",   done_flag,   1'b0);
      chk("post-abort active", active_flag, 1'b0);
      chk("post-abort tx",     data_tx,     1'b1);
      parity_type = 2'b10;
      send = 1'b1;
      run_frame("after-rst", 12'h694, 11, 1'b0, 1'b0, 1'b0);
      frame_end("after-rst");

      // Mid-frame input changes do not disturb the current frame
      reg_data    = 8'h4A;
      parity_type = 2'b01;
      send = 1'b1;
      run_frame("mut-cur", 12'h494, 11, 1'b0, 1'b0, 1'b1);
      frame_end("mut-cur");
      send = 1'b1;
      run_frame("mut-next", 12'h76A, 11, 1'b0, 1'b0, 1'b0);
      frame_end("mut-next");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
